// File: rtl/bram_ser_pkg.sv
// Shared types and default geometry for the BRAM frame serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bram_ser_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bram_ser_shifter.sv
// Row shift register (MSB first), bit counter, optional next-row hold buffer (BRAM_PREFETCH_EN).
// Latency: load at one edge, first bit visible right after it; one bit per accepted handshake.
// Backpressure: shift state only advances on adv (valid & ready); load takes priority over adv.
module bram_ser_shifter
    import bram_ser_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic              load,
    input  logic [DATA_W-1:0] load_dat,
    input  logic              adv,
`ifdef BRAM_PREFETCH_EN
    input  logic              hold_we,
    input  logic              hold_take,
    input  logic [DATA_W-1:0] hold_dat,
    output logic              hold_full,
    output logic [DATA_W-1:0] hold_q,
`endif
    output logic              bit_out,
    output logic              cnt_zero,
    output logic              row_last
);

    localparam int BIT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  cnt_q, cnt_d;

    // Next shift/count: a fresh row load wins over advancing the current one.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = load_dat;
            cnt_d   = BIT_W'(DATA_W - 1);
        end else if (adv) begin
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Shift register and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BRAM_PREFETCH_EN
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_d;

    // Taking the buffer empties it even if a capture lands on the same edge (top bypasses that data).
    always_comb begin
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        if (hold_take) begin
            hold_full_d = 1'b0;
        end else if (hold_we) begin
            hold_full_d = 1'b1;
            hold_d      = hold_dat;
        end
    end

    // Next-row hold buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
        end
    end

    assign hold_full = hold_full_q;
`endif

    assign bit_out  = shift_q[DATA_W-1];
    assign cnt_zero = (cnt_q == '0);
    assign row_last = valid & cnt_zero;

endmodule

// File: rtl/bram_frame_serializer.sv
// Reads a DEPTH-row BRAM image and streams it MSB-first as 1-bit valid/ready with row/frame markers; BRAM_PREFETCH_EN removes the inter-row bubble.
// Latency: start at edge N -> mem_en in cycle N+1, first bit_valid in cycle N+2+RD_LAT; RD_LAT+1 idle cycles between rows without prefetch.
// Backpressure: bit_out/row_idx/markers hold while bit_valid & !bit_ready; no timeout; start ignored while busy.
module bram_frame_serializer
    import bram_ser_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic [ADDR_W-1:0] row_idx,
    output logic              row_last,
    output logic              frame_last,
    output logic              frame_done
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d, row_nxt;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              bit_valid_q, bit_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic              hshk, cnt_zero, sh_load;
    logic [DATA_W-1:0] sh_load_dat;

`ifdef BRAM_PREFETCH_EN
    // Edges until the prefetched row is on mem_dout, counted from the edge that raises mem_en.
    localparam logic [CNT_W-1:0] PF_INIT = CNT_W'(RD_LAT + 1);
    logic [CNT_W-1:0]  pf_cnt_q, pf_cnt_d;
    logic              hold_we, hold_take, hold_full;
    logic [DATA_W-1:0] hold_q;
`endif

    assign hshk    = bit_valid_q & bit_ready;
    assign row_nxt = row_q + 1'b1;

    // FSM next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        mem_en_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        bit_valid_d  = bit_valid_q;
        frame_done_d = 1'b0;
        wait_cnt_d   = wait_cnt_q;
        sh_load      = 1'b0;
        sh_load_dat  = mem_dout;
`ifdef BRAM_PREFETCH_EN
        pf_cnt_d  = pf_cnt_q;
        hold_we   = 1'b0;
        hold_take = 1'b0;
        if (pf_cnt_q != '0) begin
            pf_cnt_d = pf_cnt_q - 1'b1;
            hold_we  = (pf_cnt_q == CNT_W'(1));
        end
        // When the buffer is still empty the data is arriving this edge: bypass it.
        if (hold_full) begin
            sh_load_dat = hold_q;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    mem_en_d   = 1'b1;
                    mem_addr_d = row_q;
                end
            end
            S_FETCH: begin
                state_d    = S_WAIT;
                wait_cnt_d = CNT_W'(RD_LAT - 1);
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d     = S_SHIFT;
                    sh_load     = 1'b1;
                    bit_valid_d = 1'b1;
`ifdef BRAM_PREFETCH_EN
                    if (row_q != LAST_ROW) begin
                        mem_en_d   = 1'b1;
                        mem_addr_d = row_nxt;
                        pf_cnt_d   = PF_INIT;
                    end
`endif
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            S_SHIFT: begin
                if (hshk && cnt_zero) begin
                    if (row_q == LAST_ROW) begin
                        state_d      = S_DONE;
                        bit_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        row_d = row_nxt;
`ifdef BRAM_PREFETCH_EN
                        sh_load   = 1'b1;
                        hold_take = 1'b1;
                        if (row_nxt != LAST_ROW) begin
                            mem_en_d   = 1'b1;
                            mem_addr_d = row_nxt + 1'b1;
                            pf_cnt_d   = PF_INIT;
                        end
`else
                        state_d     = S_FETCH;
                        bit_valid_d = 1'b0;
                        mem_en_d    = 1'b1;
                        mem_addr_d  = row_nxt;
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                row_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            wait_cnt_q   <= '0;
`ifdef BRAM_PREFETCH_EN
            pf_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
            wait_cnt_q   <= wait_cnt_d;
`ifdef BRAM_PREFETCH_EN
            pf_cnt_q     <= pf_cnt_d;
`endif
        end
    end

    bram_ser_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .valid     (bit_valid_q),
        .load      (sh_load),
        .load_dat  (sh_load_dat),
        .adv       (hshk),
`ifdef BRAM_PREFETCH_EN
        .hold_we   (hold_we),
        .hold_take (hold_take),
        .hold_dat  (mem_dout),
        .hold_full (hold_full),
        .hold_q    (hold_q),
`endif
        .bit_out   (bit_out),
        .cnt_zero  (cnt_zero),
        .row_last  (row_last)
    );

    assign busy       = (state_q != S_IDLE);
    assign mem_en     = mem_en_q;
    assign mem_addr   = mem_addr_q;
    assign bit_valid  = bit_valid_q;
    assign row_idx    = row_q;
    assign frame_last = row_last & (row_q == LAST_ROW);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bram_frame_serializer.sv
// Randomized bench: BRAM image streamed bit by bit and compared against the image read in row/MSB order.
module tb_bram_frame_serializer;

`ifdef BRAM_PREFETCH_EN
    localparam int EXP_BUB = 0;
`else
    localparam int EXP_BUB = 14;
`endif

    logic       clk = 1'b0;
    logic       reset, start, bit_ready;
    logic       busy, mem_en, bit_out, bit_valid, row_last, frame_last, frame_done;
    logic [2:0] mem_addr, row_idx;
    logic [7:0] mem_dout;
    logic [7:0] img [8];

    int n_checks = 0;
    int n_errors = 0;
    bit ab;

    always #5 clk = ~clk;

    bram_frame_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .row_idx    (row_idx),
        .row_last   (row_last),
        .frame_last (frame_last),
        .frame_done (frame_done)
    );

    // Single-cycle-latency BRAM read port.
    always @(posedge clk) begin
        if (mem_en) mem_dout <= img[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_valid", 32'(bit_valid), 0);
        chk("rst_bit", 32'(bit_out), 0);
        chk("rst_row", 32'(row_idx), 0);
        chk("rst_row_last", 32'(row_last), 0);
        chk("rst_frame_last", 32'(frame_last), 0);
        chk("rst_done", 32'(frame_done), 0);
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(frame_done), 0);
            chk("idle_valid", 32'(bit_valid), 0);
        end
    endtask

    // mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic run_frame(input int mode, input bit hold_start, input bit chk_timing,
                             input int abort_at, input int mid_start_at, output bit aborted);
        int acc, cyc, bub;
        bit done_seen, pv, pr, pb;
        logic [2:0] prow, ri, bi;
        logic [3:0] pat;
        logic [1:0] pi;
        pat = 4'b1001;
        acc = 0; cyc = 0; bub = 0;
        done_seen = 0; pv = 0; pr = 0; pb = 0; prow = '0;
        aborted = 0;
        @(negedge clk);
        start = 1'b1;
        bit_ready = (mode == 0);
        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = hold_start || (mid_start_at > 0 && acc == mid_start_at);
            pi = 2'(3 - (cyc % 4));
            case (mode)
                0:       bit_ready = 1'b1;
                1:       bit_ready = pat[pi];
                default: bit_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (chk_timing && cyc == 1) begin
                chk("t_mem_en", 32'(mem_en), 1);
                chk("t_mem_addr", 32'(mem_addr), 0);
                chk("t_busy", 32'(busy), 1);
            end
            if (chk_timing && cyc == 2) chk("t_no_valid", 32'(bit_valid), 0);
            if (chk_timing && cyc == 3) chk("t_first_valid", 32'(bit_valid), 1);
            if (pv && !pr) begin
                chk("stall_valid", 32'(bit_valid), 1);
                chk("stall_bit", 32'(bit_out), 32'(pb));
                chk("stall_row", 32'(row_idx), 32'(prow));
            end
            if (!bit_valid && acc > 0 && acc < 64) bub++;
            if (frame_done) begin
                done_seen = 1;
                chk("done_count", 32'(acc), 64);
                chk("done_valid", 32'(bit_valid), 0);
                chk("done_busy", 32'(busy), 1);
            end else if (bit_valid && bit_ready) begin
                if (acc >= 64) begin
                    chk("overrun", 32'(acc), 63);
                    break;
                end
                ri = 3'(acc / 8);
                bi = 3'(7 - (acc % 8));
                chk("bit", 32'(bit_out), 32'(img[ri][bi]));
                chk("row_idx", 32'(row_idx), 32'(ri));
                chk("row_last", 32'(row_last), 32'(bi == 3'd0));
                chk("frame_last", 32'(frame_last), 32'(acc == 63));
                acc++;
                if (acc == abort_at) begin
                    aborted = 1;
                    break;
                end
            end
            pv = bit_valid; pr = bit_ready; pb = bit_out; prow = row_idx;
        end
        if (!aborted) begin
            chk("frame_end", 32'(done_seen), 1);
            if (mode == 0) chk("bubbles", 32'(bub), 32'(EXP_BUB));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; bit_ready = 1'b0;
        img[0] = 8'h00; img[1] = 8'h3E; img[2] = 8'h00; img[3] = 8'h0C;
        img[4] = 8'h00; img[5] = 8'h18; img[6] = 8'h00; img[7] = 8'h60;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;

        // Reference image, ready always high, then stalling pattern.
        run_frame(0, 0, 1, 0, -1, ab);
        idle_check(3);
        run_frame(1, 0, 1, 0, -1, ab);
        idle_check(2);

        // Reset on the 20th accepted bit, then a clean replay.
        run_frame(0, 0, 1, 20, -1, ab);
        chk("abort_hit", 32'(ab), 1);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        idle_check(3);
        run_frame(0, 0, 1, 0, -1, ab);
        idle_check(2);

        // start while busy is dropped.
        run_frame(2, 0, 1, 0, 30, ab);
        idle_check(4);

        // start held high: DONE, one IDLE cycle, then the next frame.
        run_frame(0, 1, 1, 0, -1, ab);
        @(negedge clk);
        chk("b2b_idle_busy", 32'(busy), 0);
        chk("b2b_idle_en", 32'(mem_en), 0);
        @(negedge clk);
        chk("b2b_fetch_busy", 32'(busy), 1);
        chk("b2b_fetch_en", 32'(mem_en), 1);
        chk("b2b_fetch_addr", 32'(mem_addr), 0);
        run_frame(0, 1, 0, 0, -1, ab);
        start = 1'b0;
        idle_check(3);

        // Random images under random and full-rate backpressure.
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 8; r++) img[r] = 8'($urandom);
            run_frame((k == 3) ? 0 : 2, 0, 1, 0, -1, ab);
            idle_check(2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
